sdram_bank_model: RTL and testbench

//  Cycle-level behavioural model of a 4-bank SDRAM. Sits directly downstream of the SDRAM command controller.

---
 rtl/sdram_bank_model.sv | 139 +++++++++++++
 tb/tb_sdram_bank_model.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bank_model.sv
// Cycle-level model of a 4-bank SDRAM. It decodes the CS#/RAS#/CAS#/WE# command
// bus, keeps track of the open row and tRCD timer of each bank, stores write data,
// and returns read data after CAS_LATENCY. Illegal commands are ignored and
// reported with a one-cycle error pulse.
//
// state        | meaning
// BANK_IDLE    | no row open; ACT is legal, READ/WRITE are errors
// BANK_ACTIVE  | row open; READ/WRITE are legal once the tRCD timer reaches 0
module sdram_bank_model #(
    parameter int CAS_LATENCY = 2,
    parameter int TRCD        = 2,
    parameter int ROW_BITS    = 4,
    parameter int COL_BITS    = 4
) (
    input  logic        in_HCLK,
    input  logic        in_HRESET,
    input  logic        in_CS,
    input  logic        in_RAS,
    input  logic        in_CAS,
    input  logic        in_write_en,
    input  logic [1:0]  in_bank_select,
    input  logic [13:0] in_sdram_addr,
    input  logic [31:0] in_sdram_write_data,
    output logic [31:0] out_sdram_read_data,
    output logic        out_read_valid,
    output logic        out_cmd_error
);

    localparam int CNT_W  = (TRCD > 1) ? $clog2(TRCD) : 1;
    localparam int MEM_AW = 2 + ROW_BITS + COL_BITS;

    typedef enum logic {
        BANK_IDLE,
        BANK_ACTIVE
    } bank_state_t;

    bank_state_t         bank_state [4];
    logic [ROW_BITS-1:0] open_row   [4];
    logic [CNT_W-1:0]    trcd_cnt   [4];

    logic [31:0]         mem        [0:(1<<MEM_AW)-1];

    logic                pipe_valid [CAS_LATENCY];
    logic [31:0]         pipe_data  [CAS_LATENCY];

    logic [3:0]          cmd;
    logic                is_act, is_read, is_write, is_pre, is_ref;
    logic                any_active, bank_ready;
    logic                do_act, do_read, do_write, cmd_err;
    logic [MEM_AW-1:0]   mem_idx;
    logic                unused_addr;

    assign cmd      = {in_CS, in_RAS, in_CAS, in_write_en};
    assign is_act   = (cmd == 4'b0011);
    assign is_read  = (cmd == 4'b0101);
    assign is_write = (cmd == 4'b0100);
    assign is_pre   = (cmd == 4'b0010);
    assign is_ref   = (cmd == 4'b0001);

    // Only the row/column LSBs and the all-banks bit carry meaning here.
    assign unused_addr = ^in_sdram_addr;

    // REFRESH legality needs to know whether any bank still has a row open.
    always_comb begin
        any_active = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (bank_state[b] == BANK_ACTIVE) any_active = 1'b1;
        end
    end

    assign bank_ready = (bank_state[in_bank_select] == BANK_ACTIVE) &&
                        (trcd_cnt[in_bank_select] == '0);
    assign do_act     = is_act && (bank_state[in_bank_select] == BANK_IDLE);
    assign do_read    = is_read && bank_ready;
    assign do_write   = is_write && bank_ready;
    assign cmd_err    = (is_act && (bank_state[in_bank_select] == BANK_ACTIVE)) ||
                        ((is_read || is_write) && !bank_ready) ||
                        (is_ref && any_active);
    assign mem_idx    = {in_bank_select, open_row[in_bank_select],
                         in_sdram_addr[COL_BITS-1:0]};

    // Per-bank open/close state, open row and tRCD down-counter.
    always_ff @(posedge in_HCLK) begin
        if (in_HRESET) begin
            for (int b = 0; b < 4; b++) begin
                bank_state[b] <= BANK_IDLE;
                open_row[b]   <= '0;
                trcd_cnt[b]   <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bank_state[b] == BANK_ACTIVE && trcd_cnt[b] != '0)
                    trcd_cnt[b] <= trcd_cnt[b] - CNT_W'(1);
                if (do_act && in_bank_select == 2'(b)) begin
                    bank_state[b] <= BANK_ACTIVE;
                    open_row[b]   <= in_sdram_addr[ROW_BITS-1:0];
                    trcd_cnt[b]   <= CNT_W'(TRCD - 1);
                end
                if (is_pre && (in_sdram_addr[10] || in_bank_select == 2'(b))) begin
                    bank_state[b] <= BANK_IDLE;
                    trcd_cnt[b]   <= '0;
                end
            end
        end
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge in_HCLK) begin
        if (!in_HRESET && do_write)
            mem[mem_idx] <= in_sdram_write_data;
    end

    // CAS latency pipeline; non-read slots carry zero so the output is 0 when idle.
    always_ff @(posedge in_HCLK) begin
        if (in_HRESET) begin
            for (int i = 0; i < CAS_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_data[i]  <= '0;
            end
        end else begin
            pipe_valid[0] <= do_read;
            pipe_data[0]  <= do_read ? mem[mem_idx] : 32'h0;
            for (int i = 1; i < CAS_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    // Error pulse appears in the cycle after the offending command.
    always_ff @(posedge in_HCLK) begin
        if (in_HRESET) out_cmd_error <= 1'b0;
        else           out_cmd_error <= cmd_err;
    end

    assign out_read_valid      = pipe_valid[CAS_LATENCY-1];
    assign out_sdram_read_data = pipe_data[CAS_LATENCY-1];

endmodule

// File: tb/tb_sdram_bank_model.sv
// Directed bench for sdram_bank_model with a per-cycle reference model.
module tb_sdram_bank_model;

    localparam int CL   = 2;
    localparam int TRCD = 2;

    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_READ  = 4'b0101;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_PRE   = 4'b0010;
    localparam logic [3:0] C_REF   = 4'b0001;

    logic        in_HCLK = 1'b0;
    logic        in_HRESET;
    logic        in_CS, in_RAS, in_CAS, in_write_en;
    logic [1:0]  in_bank_select;
    logic [13:0] in_sdram_addr;
    logic [31:0] in_sdram_write_data;
    logic [31:0] out_sdram_read_data;
    logic        out_read_valid;
    logic        out_cmd_error;

    int pass_cnt = 0;
    int total_cnt = 0;

    sdram_bank_model #(.CAS_LATENCY(CL), .TRCD(TRCD), .ROW_BITS(4), .COL_BITS(4)) dut (
        .in_HCLK(in_HCLK),
        .in_HRESET(in_HRESET),
        .in_CS(in_CS),
        .in_RAS(in_RAS),
        .in_CAS(in_CAS),
        .in_write_en(in_write_en),
        .in_bank_select(in_bank_select),
        .in_sdram_addr(in_sdram_addr),
        .in_sdram_write_data(in_sdram_write_data),
        .out_sdram_read_data(out_sdram_read_data),
        .out_read_valid(out_read_valid),
        .out_cmd_error(out_cmd_error)
    );

    always #5 in_HCLK = ~in_HCLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected)
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        else
            pass_cnt++;
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    bit          model_live = 0;
    bit          open_m  [4];
    int          row_m   [4];
    int          act_at  [4];
    logic [31:0] mem_m   [int];
    logic [31:0] due_data[int];
    bit          exp_valid, exp_err;
    logic [31:0] exp_data;
    logic [3:0]  m_cmd;
    int          m_bank, m_key;

    always @(posedge in_HCLK) begin
        m_cmd  = {in_CS, in_RAS, in_CAS, in_write_en};
        m_bank = int'(in_bank_select);
        if (in_HRESET) begin
            for (int i = 0; i < 4; i++) open_m[i] = 0;
            due_data.delete();
            exp_valid  = 0;
            exp_err    = 0;
            exp_data   = 0;
            model_live = 1;
        end else begin
            exp_err = 0;
            if (m_cmd == C_ACT) begin
                if (open_m[m_bank]) exp_err = 1;
                else begin
                    open_m[m_bank] = 1;
                    row_m[m_bank]  = int'(in_sdram_addr[3:0]);
                    act_at[m_bank] = cyc;
                end
            end else if (m_cmd == C_READ || m_cmd == C_WRITE) begin
                if (!open_m[m_bank] || (cyc - act_at[m_bank]) < TRCD) exp_err = 1;
                else begin
                    m_key = m_bank * 256 + row_m[m_bank] * 16 + int'(in_sdram_addr[3:0]);
                    if (m_cmd == C_WRITE) mem_m[m_key] = in_sdram_write_data;
                    else due_data[cyc + CL - 1] = mem_m.exists(m_key) ? mem_m[m_key] : 32'h0;
                end
            end else if (m_cmd == C_PRE) begin
                if (in_sdram_addr[10]) for (int i = 0; i < 4; i++) open_m[i] = 0;
                else open_m[m_bank] = 0;
            end else if (m_cmd == C_REF) begin
                for (int i = 0; i < 4; i++) if (open_m[i]) exp_err = 1;
            end
            exp_valid = due_data.exists(cyc);
            exp_data  = exp_valid ? due_data[cyc] : 32'h0;
            if (exp_valid) due_data.delete(cyc);
        end
        cyc++;
    end

    // Compare DUT against the model every cycle once reset has been seen.
    always @(negedge in_HCLK) begin
        if (model_live) begin
            check("model_valid", {31'b0, out_read_valid}, {31'b0, exp_valid});
            check("model_error", {31'b0, out_cmd_error}, {31'b0, exp_err});
            check("model_data", out_sdram_read_data, exp_data);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge in_HCLK);
        #1;
    endtask

    task automatic drive_nop();
        {in_CS, in_RAS, in_CAS, in_write_en} = C_NOP;
        in_bank_select      = 2'd0;
        in_sdram_addr       = 14'd0;
        in_sdram_write_data = 32'd0;
    endtask

    task automatic do_cmd(input logic [3:0] c, input int b, input int a, input logic [31:0] d);
        {in_CS, in_RAS, in_CAS, in_write_en} = c;
        in_bank_select      = 2'(b);
        in_sdram_addr       = 14'(a);
        in_sdram_write_data = d;
        tick();
        drive_nop();
    endtask

    task automatic lit(input string name, input logic valid, input logic [31:0] data, input logic err);
        check({name, "_valid"}, {31'b0, out_read_valid}, {31'b0, valid});
        check({name, "_data"}, out_sdram_read_data, data);
        check({name, "_err"}, {31'b0, out_cmd_error}, {31'b0, err});
    endtask

    initial begin
        in_HRESET = 1'b1;
        drive_nop();
        tick();
        tick();
        lit("reset", 1'b0, 32'h0, 1'b0);
        in_HRESET = 1'b0;
        tick();

        // 1: write then read the same location on the next edge
        do_cmd(C_ACT, 1, 5, 0);
        tick();
        do_cmd(C_WRITE, 1, 3, 32'hDEADBEEF);
        do_cmd(C_READ, 1, 3, 0);
        lit("t1_read_edge", 1'b0, 32'h0, 1'b0);
        tick();
        lit("t1_cl", 1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        lit("t1_after", 1'b0, 32'h0, 1'b0);

        // 2: read to an idle bank
        do_cmd(C_READ, 2, 0, 0);
        lit("t2_err", 1'b0, 32'h0, 1'b1);
        tick();
        lit("t2_next", 1'b0, 32'h0, 1'b0);

        // 3: tRCD violation then retry
        do_cmd(C_ACT, 0, 7, 0);
        tick();
        do_cmd(C_WRITE, 0, 1, 32'hCAFE0001);
        do_cmd(C_PRE, 0, 0, 0);
        do_cmd(C_ACT, 0, 7, 0);
        do_cmd(C_READ, 0, 1, 0);
        lit("t3_early", 1'b0, 32'h0, 1'b1);
        do_cmd(C_READ, 0, 1, 0);
        lit("t3_retry", 1'b0, 32'h0, 1'b0);
        tick();
        lit("t3_data", 1'b1, 32'hCAFE0001, 1'b0);

        // 4: back-to-back reads
        for (int i = 0; i < 4; i++) do_cmd(C_WRITE, 0, i, 32'h11 * (i + 1));
        do_cmd(C_READ, 0, 0, 0);
        lit("t4_r0", 1'b0, 32'h0, 1'b0);
        do_cmd(C_READ, 0, 1, 0);
        lit("t4_d0", 1'b1, 32'h11, 1'b0);
        do_cmd(C_READ, 0, 2, 0);
        lit("t4_d1", 1'b1, 32'h22, 1'b0);
        do_cmd(C_READ, 0, 3, 0);
        lit("t4_d2", 1'b1, 32'h33, 1'b0);
        tick();
        lit("t4_d3", 1'b1, 32'h44, 1'b0);
        tick();
        lit("t4_end", 1'b0, 32'h0, 1'b0);

        // 5: precharge-all, refresh legality, double ACT
        do_cmd(C_PRE, 0, 1 << 10, 0);
        do_cmd(C_ACT, 0, 1, 0);
        do_cmd(C_ACT, 3, 2, 0);
        do_cmd(C_PRE, 0, 1 << 10, 0);
        do_cmd(C_REF, 0, 0, 0);
        lit("t5_ref_ok", 1'b0, 32'h0, 1'b0);
        do_cmd(C_ACT, 0, 1, 0);
        do_cmd(C_ACT, 0, 1, 0);
        lit("t5_double_act", 1'b0, 32'h0, 1'b1);
        do_cmd(C_REF, 0, 0, 0);
        lit("t5_ref_bad", 1'b0, 32'h0, 1'b1);
        do_cmd(C_PRE, 0, 1 << 10, 0);

        // precharge while a read is in flight keeps the data
        do_cmd(C_ACT, 1, 5, 0);
        tick();
        do_cmd(C_READ, 1, 3, 0);
        do_cmd(C_PRE, 1, 0, 0);
        lit("pre_inflight", 1'b1, 32'hDEADBEEF, 1'b0);
        tick();

        // 6: reset right after a read drops it
        do_cmd(C_ACT, 1, 5, 0);
        tick();
        do_cmd(C_READ, 1, 3, 0);
        in_HRESET = 1'b1;
        tick();
        lit("t6_reset", 1'b0, 32'h0, 1'b0);
        in_HRESET = 1'b0;
        tick();
        lit("t6_after1", 1'b0, 32'h0, 1'b0);
        tick();
        lit("t6_after2", 1'b0, 32'h0, 1'b0);
        do_cmd(C_READ, 1, 3, 0);
        lit("t6_bank_idle", 1'b0, 32'h0, 1'b1);
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
